// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding, default width and generator seed for the sequence link
package seq_pkg;
   typedef enum logic [1:0] {ACQ, CHECK, LOCKED} state_t;
   localparam int DEF_WIDTH = 32;
   localparam int SEED_0 = 1;
   localparam int SEED_1 = 1;
   localparam int SEED_2 = 0;
endpackage

// File: rtl/seq_hist.sv
// seq_hist: 3-deep sample history with next-term prediction a(n-2)+a(n-3)
module seq_hist #(
   parameter int WIDTH = seq_pkg::DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] pred
);
   logic [WIDTH-1:0] h0, h1, h2;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h0 <= '0;
         h1 <= '0;
         h2 <= '0;
      end else if (en) begin
         h2 <= h1;
         h1 <= h0;
         h0 <= d;
      end
   end
   assign pred = h1 + h2;
endmodule

// File: rtl/seq_checker.sv
// seq_checker: acquires, locks onto and error-counts an a(n)=a(n-2)+a(n-3) word stream
module seq_checker
   import seq_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int LOCK_CNT = 4,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] seq_i,
   input  logic             clr_i,
   output logic             locked_o,
   output logic             err_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic [WIDTH-1:0] expect_o
);
   state_t           state, state_n;
   logic [1:0]       fill, fill_n;
   logic [7:0]       run, run_n, run_inc;
   logic             err_n, match;
   logic [CNT_W-1:0] cnt_base, cnt_n;

   seq_hist #(.WIDTH(WIDTH)) u_hist (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (valid_i),
      .d       (seq_i),
      .pred    (expect_o)
   );

   assign match   = seq_i == expect_o;
   assign run_inc = run + 8'd1;

   always_comb begin
      state_n = state;
      fill_n  = fill;
      run_n   = run;
      err_n   = 1'b0;
      if (valid_i) begin
         case (state)
            ACQ: begin
               fill_n = fill + 2'd1;
               if (fill == 2'd2) begin
                  state_n = CHECK;
                  run_n   = '0;
               end
            end
            CHECK: begin
               run_n = match ? run_inc : '0;
               if (match && run_inc == 8'(LOCK_CNT)) state_n = LOCKED;
            end
            LOCKED: if (!match) begin
               err_n   = 1'b1;
               state_n = CHECK;
               run_n   = '0;
            end
            default: state_n = ACQ;
         endcase
      end
   end

   // clear applies before the increment so a coincident error leaves a count of one
   assign cnt_base = clr_i ? '0 : err_cnt_o;
   assign cnt_n    = (err_n && !(&cnt_base)) ? cnt_base + 1'b1 : cnt_base;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ACQ;
         fill      <= '0;
         run       <= '0;
         err_o     <= 1'b0;
         locked_o  <= 1'b0;
         err_cnt_o <= '0;
      end else begin
         state     <= state_n;
         fill      <= fill_n;
         run       <= run_n;
         err_o     <= err_n;
         locked_o  <= state_n == LOCKED;
         err_cnt_o <= cnt_n;
      end
   end
endmodule

// File: doc/seq_checker.md
Name: seq_checker

Overview:
- Receive-side companion to the sequence generator.
- Consumes a stream of sequence words and checks them against the recurrence a(n) = a(n-2) + a(n-3), computed modulo 2^WIDTH.
- Acquires the stream from any 3 consecutive samples, declares lock after LOCK_CNT consecutive correct predictions, and flags and counts errors while locked.
- Sits at the sink of a generator link. Used for link integrity checking and as a self-checking monitor in benches.

Parameters:
- WIDTH, 32, data width of the sequence word; arithmetic wraps modulo 2^WIDTH.
- LOCK_CNT, 4, consecutive matches required to assert lock; legal range 1..255.
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- valid_i  input  1  seq_i carries a sample this cycle; gaps allowed; no backpressure.
- seq_i  input  WIDTH  incoming sequence word.
- clr_i  input  1  synchronous clear of err_cnt_o.
- locked_o  output  1  stream verified; registered.
- err_o  output  1  one-cycle pulse: mismatch detected while locked.
- err_cnt_o  output  CNT_W  number of locked mismatches, saturating.
- expect_o  output  WIDTH  predicted value of the next sample; meaningful when state != ACQ.

Behaviour:
- History registers h0 (newest), h1, h2 (oldest).
- Prediction: pred = h1 + h2, truncated to WIDTH bits (wrap, no carry out).
- expect_o = pred, combinational from the history registers.
- Each accepted sample (valid_i=1) shifts the history: h2<=h1, h1<=h0, h0<=seq_i. This happens in every state, matching or not.
- Reset (async, reset_n=0) values:
  - state=ACQ, fill=0, run=0
  - h0/h1/h2=0
  - locked_o=0, err_o=0, err_cnt_o=0
  - Reset mid-stream drops locked_o immediately, with no err_o pulse.
- States:
  - ACQ:
    - Each accepted sample increments fill.
    - After the 3rd sample, go to CHECK with run=0.
    - No comparisons are made in ACQ.
  - CHECK:
    - Accepted sample equal to pred: run++.
    - If the new run value equals LOCK_CNT, go to LOCKED; locked_o=1 from the next cycle.
    - Accepted sample not equal to pred: run=0, stay in CHECK, no err_o. The shifted window becomes the new seed.
  - LOCKED:
    - Match: stay in LOCKED.
    - Mismatch: err_o=1 for exactly the next cycle; err_cnt_o increments (saturating at 2^CNT_W-1); go to CHECK with run=0; locked_o=0 from the next cycle.
- valid_i=0: all state holds and err_o=0.
- Latency: err_o and locked_o reflect the sample accepted on the previous edge (1 cycle).
- clr_i and an error in the same cycle: err_cnt_o becomes 1 (clear first, then increment). clr_i alone sets err_cnt_o to 0.
- At saturation, further errors still pulse err_o, but err_cnt_o holds.
- LOCK_CNT=1: a single match in CHECK locks.

Decomposition:
- Shared package seq_pkg:
  - state enum typedef (ACQ, CHECK, LOCKED)
  - default WIDTH constant
  - generator seed constants (1, 1, 0), shared with the generator and used by benches
- Sub-module seq_hist:
  - 3-deep shift history with shift enable
  - pred adder output
  - reusable by future generator variants
- seq_checker holds the FSM, fill/run counters and error counter.

Test Plan:
- Clean generator stream, LOCK_CNT=4: feed 0,1,1,1,2,2,3 on consecutive cycles -> no comparisons on the first three; matches on 1,2,2,3; locked_o=1 the cycle after sample 3; err_o never asserted; expect_o=4 after sample 3.
- Single corruption while locked: continue 4,5,7 then send 8 instead of 9 -> err_o pulses one cycle after 8; err_cnt_o=1; locked_o=0 on that same cycle. Then feed 12,16,21,28,37,49,65 -> no further err_o pulses; locked_o=1 again the cycle after 65.
- Wrap-around, WIDTH=8: seed 200,151,7 -> expect_o=95 (351 mod 256); sending 95 counts as a match and run increments.
- Idle gaps: the clean stream from the first scenario with valid_i=0 inserted for 1-5 random cycles between samples -> same lock point counted in samples; state, expect_o and err_cnt_o unchanged during gaps.
- Counter corners, CNT_W=2:
  - 5 locked errors -> err_cnt_o saturates at 3, and err_o still pulses 5 times.
  - clr_i coincident with an error -> err_cnt_o=1.
- Async reset mid-lock: drop reset_n between clock edges while locked -> locked_o falls with no clock edge and err_cnt_o=0. After release, the stream restarts from 0,1,1 -> re-locks after 7 samples.
